// File: rtl/uart_baud_sched_if.sv
// -----------------------------------------------------------------------------
// uart_baud_sched_if
// Requester-side bundle of the baud-generator scheduler.
//   req_i      : per-requester ownership request (held for the whole use)
//   baud_sel_i : requester i's 3-bit baud code at bits [3i+2:3i]
//   grant_o    : one-hot ownership grant returned by the scheduler
// master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface uart_baud_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_i;
  logic [3*NUM_REQ-1:0] baud_sel_i;
  logic [NUM_REQ-1:0]   grant_o;

  modport master (output req_i, output baud_sel_i, input grant_o);
  modport slave  (input req_i, input baud_sel_i, output grant_o);
endinterface

// File: rtl/uart_baud_sched.sv
// -----------------------------------------------------------------------------
// uart_baud_sched
// Round-robin owner of the single UART baud-clock generator. A winner is
// picked from the rotating pointer; if the generator already runs at the
// winner's baud code the grant is immediate, otherwise the generator is
// reprogrammed, held in reset for SETTLE_CYCLES, and the grant is issued only
// after the first rising edge of the generator clock is seen.
// Ports:
//   clk_i          : system clock (generator shares it)
//   rst_i          : synchronous active-high reset
//   bus            : requester bundle (req_i, baud_sel_i in; grant_o out)
//   gen_baud_sel_o : baud select to the generator
//   gen_rstn_o     : active-low generator reset
//   gen_uart_clk_i : generator output clock (synchronous to clk_i)
//   busy_o         : scheduler is not idle
//   err_o          : one-cycle pulse when the generator never came alive
//   err_id_o       : requester index tied to the last err_o
// -----------------------------------------------------------------------------
module uart_baud_sched #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  uart_baud_sched_if.slave           bus,
  output logic [2:0]                 gen_baud_sel_o,
  output logic                       gen_rstn_o,
  input  logic                       gen_uart_clk_i,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [$clog2(NUM_REQ)-1:0] err_id_o
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int TMAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]      SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] GRANT_ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [2:0]         SEL_RESET    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECONF = 2'd1,
    ST_SYNC   = 2'd2,
    ST_GRANT  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IW-1:0]       win_r, win_s;
  logic [IW-1:0]       last_r, last_s;
  logic                cfg_valid_r, cfg_valid_s;
  logic [TW-1:0]       timer_r, timer_s;
  logic                clk_prev_r;
  logic [NUM_REQ-1:0]  grant_r, grant_s;
  logic [2:0]          sel_r, sel_s;
  logic                rstn_r, rstn_s;
  logic                busy_r, busy_s;
  logic                err_r, err_s;
  logic [IW-1:0]       err_id_r, err_id_s;

  logic                rise_s;
  logic                req_win_s;
  logic                arb_found_s;
  logic [IW-1:0]       arb_win_s;
  logic [IW:0]         cand_s;
  logic [2:0]          arb_sel_s;

  assign rise_s    = gen_uart_clk_i & ~clk_prev_r;
  assign req_win_s = bus.req_i[win_r];

  // Rotating-priority search: first asserted request after last_r, wrapping.
  always_comb begin
    arb_found_s = 1'b0;
    arb_win_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = {1'b0, last_r} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!arb_found_s && bus.req_i[cand_s[IW-1:0]]) begin
        arb_found_s = 1'b1;
        arb_win_s   = cand_s[IW-1:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Baud code of the current arbitration winner.
  always_comb begin
    arb_sel_s = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_win_s == IW'(i)) begin
        arb_sel_s = bus.baud_sel_i[3*i +: 3];
      end else begin
        arb_sel_s = arb_sel_s;
      end
    end
  end

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    state_s     = state_r;
    win_s       = win_r;
    last_s      = last_r;
    cfg_valid_s = cfg_valid_r;
    timer_s     = timer_r;
    grant_s     = grant_r;
    sel_s       = sel_r;
    rstn_s      = rstn_r;
    err_s       = 1'b0;
    err_id_s    = err_id_r;
    case (state_r)
      ST_IDLE: begin
        grant_s = '0;
        if (arb_found_s) begin
          win_s = arb_win_s;
          if (cfg_valid_r && (arb_sel_s == sel_r)) begin
            // Generator already runs at this rate: hand over directly.
            state_s = ST_GRANT;
            grant_s = GRANT_ONE << arb_win_s;
          end else begin
            state_s     = ST_RECONF;
            sel_s       = arb_sel_s;
            rstn_s      = 1'b0;
            cfg_valid_s = 1'b0;
            timer_s     = '0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECONF: begin
        if (!req_win_s) begin
          state_s     = ST_IDLE;
          rstn_s      = 1'b0;
          cfg_valid_s = 1'b0;
          last_s      = win_r;
          timer_s     = '0;
        end else if (timer_r == SETTLE_LAST) begin
          state_s = ST_SYNC;
          rstn_s  = 1'b1;
          timer_s = '0;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_SYNC: begin
        if (!req_win_s) begin
          state_s     = ST_IDLE;
          rstn_s      = 1'b0;
          cfg_valid_s = 1'b0;
          last_s      = win_r;
          timer_s     = '0;
        end else if (rise_s) begin
          state_s     = ST_GRANT;
          cfg_valid_s = 1'b1;
          grant_s     = GRANT_ONE << win_r;
        end else if (timer_r == TIMEOUT_LAST) begin
          // Generator never toggled: give up and move the pointer on.
          state_s     = ST_IDLE;
          err_s       = 1'b1;
          err_id_s    = win_r;
          last_s      = win_r;
          rstn_s      = 1'b0;
          cfg_valid_s = 1'b0;
          timer_s     = '0;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_GRANT: begin
        if (!req_win_s) begin
          state_s = ST_IDLE;
          grant_s = '0;
          last_s  = win_r;
        end else begin
          grant_s = GRANT_ONE << win_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      win_r       <= '0;
      last_r      <= IW'(NUM_REQ - 1);
      cfg_valid_r <= 1'b0;
      timer_r     <= '0;
      clk_prev_r  <= 1'b0;
      grant_r     <= '0;
      sel_r       <= SEL_RESET;
      rstn_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      err_id_r    <= '0;
    end else begin
      state_r     <= state_s;
      win_r       <= win_s;
      last_r      <= last_s;
      cfg_valid_r <= cfg_valid_s;
      timer_r     <= timer_s;
      clk_prev_r  <= gen_uart_clk_i;
      grant_r     <= grant_s;
      sel_r       <= sel_s;
      rstn_r      <= rstn_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
      err_id_r    <= err_id_s;
    end
  end

  assign bus.grant_o    = grant_r;
  assign gen_baud_sel_o = sel_r;
  assign gen_rstn_o     = rstn_r;
  assign busy_o         = busy_r;
  assign err_o          = err_r;
  assign err_id_o       = err_id_r;

endmodule

// File: tb/tb_uart_baud_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_sched
// Two scheduler instances: "a" (TIMEOUT=65535) paired with a generator model
// whose half period follows a 100 MHz clock (code 5 -> 434 cycles), and "b"
// (TIMEOUT=100) paired with a fast generator that can be held dead.
// A transaction-level model predicts all outputs; a negedge process compares
// every cycle; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_baud_sched;
  localparam int N        = 4;
  localparam int SETTLE   = 4;
  localparam int TO_MAIN  = 65535;
  localparam int TO_SHORT = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  uart_baud_sched_if #(.NUM_REQ(N)) bus_a ();
  uart_baud_sched_if #(.NUM_REQ(N)) bus_b ();

  logic       rst_a, rst_b;
  logic [2:0] sel_a, sel_b;
  logic       rstn_a, rstn_b;
  logic       gclk_a = 1'b0, gclk_b = 1'b0;
  logic       busy_a, busy_b, err_a, err_b;
  logic [1:0] errid_a, errid_b;
  bit         dead_b = 1'b1;
  int         gcnt_a = 0, gcnt_b = 0;

  uart_baud_sched #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TO_MAIN)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a), .gen_baud_sel_o(sel_a),
    .gen_rstn_o(rstn_a), .gen_uart_clk_i(gclk_a), .busy_o(busy_a),
    .err_o(err_a), .err_id_o(errid_a));

  uart_baud_sched #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TO_SHORT)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b), .gen_baud_sel_o(sel_b),
    .gen_rstn_o(rstn_b), .gen_uart_clk_i(gclk_b), .busy_o(busy_b),
    .err_o(err_b), .err_id_o(errid_b));

  // Half period (in 100 MHz cycles) of the baud clock for each code.
  function automatic int half_of(input logic [2:0] c);
    case (c)
      3'd0: half_of = 10417;
      3'd1: half_of = 5208;
      3'd2: half_of = 2604;
      3'd3: half_of = 1302;
      3'd4: half_of = 868;
      3'd5: half_of = 434;
      3'd6: half_of = 217;
      default: half_of = 109;
    endcase
  endfunction

  // Generator model for instance a.
  always @(posedge clk) begin
    if (!rstn_a) begin
      gclk_a <= 1'b0; gcnt_a <= 0;
    end else if (gcnt_a == half_of(sel_a) - 1) begin
      gclk_a <= ~gclk_a; gcnt_a <= 0;
    end else begin
      gcnt_a <= gcnt_a + 1;
    end
  end

  // Fast generator model for instance b; dead_b keeps it silent.
  always @(posedge clk) begin
    if (!rstn_b || dead_b) begin
      gclk_b <= 1'b0; gcnt_b <= 0;
    end else if (gcnt_b == 7) begin
      gclk_b <= ~gclk_b; gcnt_b <= 0;
    end else begin
      gcnt_b <= gcnt_b + 1;
    end
  end

  // ---------------- behavioural model ----------------
  int         m_owner[2], m_win[2], m_last[2], m_settle[2], m_age[2], m_errid[2];
  int         m_to[2];
  bit         m_sync[2], m_cfg[2], m_prev[2], m_rstn[2], m_err[2];
  logic [2:0] m_sel[2];
  bit         model_ok = 1'b0;

  task automatic model_abort(input int k);
    m_rstn[k] = 1'b0; m_cfg[k] = 1'b0; m_last[k] = m_win[k];
    m_settle[k] = 0; m_sync[k] = 1'b0;
  endtask

  task automatic model_step(input int k, input bit rst, input logic [N-1:0] r,
                            input logic [3*N-1:0] bs, input bit gclk);
    bit         rise;
    int         w;
    logic [2:0] lsel;
    rise = gclk && !m_prev[k];
    m_err[k] = 1'b0;
    if (rst) begin
      m_owner[k] = -1; m_win[k] = 0; m_last[k] = N - 1; m_settle[k] = 0;
      m_sync[k] = 1'b0; m_age[k] = 0; m_cfg[k] = 1'b0; m_sel[k] = 3'd5;
      m_rstn[k] = 1'b0; m_errid[k] = 0; m_prev[k] = 1'b0;
    end else begin
      if (m_owner[k] >= 0) begin
        if (!r[m_owner[k]]) begin
          m_last[k] = m_owner[k]; m_owner[k] = -1;
        end
      end else if (m_settle[k] > 0) begin
        if (!r[m_win[k]]) model_abort(k);
        else begin
          m_settle[k]--;
          if (m_settle[k] == 0) begin
            m_rstn[k] = 1'b1; m_sync[k] = 1'b1; m_age[k] = 0;
          end
        end
      end else if (m_sync[k]) begin
        if (!r[m_win[k]]) model_abort(k);
        else if (rise) begin
          m_owner[k] = m_win[k]; m_cfg[k] = 1'b1; m_sync[k] = 1'b0;
        end else begin
          m_age[k]++;
          if (m_age[k] == m_to[k]) begin
            m_err[k] = 1'b1; m_errid[k] = m_win[k];
            model_abort(k);
          end
        end
      end else if (r != '0) begin
        w = -1;
        for (int s = 1; s <= N; s++) begin
          int c;
          c = (m_last[k] + s) % N;
          if (w < 0 && r[c]) w = c;
        end
        m_win[k] = w;
        lsel = bs[3*w +: 3];
        if (m_cfg[k] && lsel == m_sel[k]) m_owner[k] = w;
        else begin
          m_sel[k] = lsel; m_rstn[k] = 1'b0; m_cfg[k] = 1'b0; m_settle[k] = SETTLE;
        end
      end
      m_prev[k] = gclk;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, bus_a.req_i, bus_a.baud_sel_i, gclk_a);
    model_step(1, rst_b, bus_b.req_i, bus_b.baud_sel_i, gclk_b);
    model_ok = 1'b1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_fail = 0;
  int err_cnt_a = 0, err_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_grant(input int k);
    if (m_owner[k] >= 0) exp_grant = N'(1) << m_owner[k];
    else exp_grant = '0;
  endfunction

  function automatic bit exp_busy(input int k);
    exp_busy = (m_owner[k] >= 0) || (m_settle[k] > 0) || m_sync[k];
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("a.grant",  32'(bus_a.grant_o), 32'(exp_grant(0)));
      check("a.sel",    32'(sel_a),   32'(m_sel[0]));
      check("a.rstn",   32'(rstn_a),  32'(m_rstn[0]));
      check("a.busy",   32'(busy_a),  32'(exp_busy(0)));
      check("a.err",    32'(err_a),   32'(m_err[0]));
      check("a.err_id", 32'(errid_a), 32'(m_errid[0]));
      check("b.grant",  32'(bus_b.grant_o), 32'(exp_grant(1)));
      check("b.sel",    32'(sel_b),   32'(m_sel[1]));
      check("b.rstn",   32'(rstn_b),  32'(m_rstn[1]));
      check("b.busy",   32'(busy_b),  32'(exp_busy(1)));
      check("b.err",    32'(err_b),   32'(m_err[1]));
      check("b.err_id", 32'(errid_b), 32'(m_errid[1]));
      if (err_a) err_cnt_a++;
      if (err_b) err_cnt_b++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    idx_of = -1;
    for (int i = 0; i < N; i++) if (g[i]) idx_of = i;
  endfunction

  task automatic wait_grant_a(input string tag, input int limit, output int cyc, output int lowc);
    cyc = 0; lowc = 0;
    while (bus_a.grant_o == '0 && cyc < limit) begin
      tick(); cyc++;
      if (!rstn_a) lowc++;
    end
    check({tag, "_grant_seen"}, 32'(bus_a.grant_o != '0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lowc, idx, gseen;
    int order_exp[5];
    m_to[0] = TO_MAIN; m_to[1] = TO_SHORT;
    order_exp = '{0, 1, 2, 3, 0};
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.req_i = '0; bus_a.baud_sel_i = '0;
    bus_b.req_i = '0; bus_b.baud_sel_i = '0;
    repeat (3) tick();
    check("rst_sel",   32'(sel_a), 32'd5);
    check("rst_rstn",  32'(rstn_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_grant", 32'(bus_a.grant_o), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // 1: single request, code 5 -> reconfigure then grant after first rise
    bus_a.baud_sel_i = {3'd0, 3'd0, 3'd0, 3'd5};
    bus_a.req_i = 4'b0001;
    wait_grant_a("t1", 2000, cyc, lowc);
    check("t1_latency", 32'(cyc), 32'd440);
    check("t1_rstn_low", 32'(lowc), 32'd4);
    check("t1_grant", 32'(bus_a.grant_o), 32'b0001);
    check("t1_sel", 32'(sel_a), 32'd5);

    // 2: matching code hands over without reconfiguration
    bus_a.baud_sel_i = {3'd0, 3'd5, 3'd0, 3'd5};
    bus_a.req_i = 4'b0101;
    repeat (3) tick();
    check("t2_hold", 32'(bus_a.grant_o), 32'b0001);
    bus_a.req_i = 4'b0100;
    tick();
    check("t2_idle_grant", 32'(bus_a.grant_o), 32'd0);
    check("t2_idle_rstn", 32'(rstn_a), 32'd1);
    tick();
    check("t2_grant", 32'(bus_a.grant_o), 32'b0100);
    check("t2_rstn", 32'(rstn_a), 32'd1);

    // 3: four requesters with distinct codes, round-robin order
    rst_a = 1'b1; bus_a.req_i = '0;
    repeat (2) tick();
    rst_a = 1'b0;
    bus_a.baud_sel_i = {3'd3, 3'd7, 3'd6, 3'd4};
    bus_a.req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant_a("t3", 5000, cyc, lowc);
      idx = idx_of(bus_a.grant_o);
      check("t3_order", 32'(idx), 32'(order_exp[g]));
      check("t3_rstn_low", 32'(lowc), 32'd4);
      repeat (10) tick();
      if (idx >= 0) bus_a.req_i[idx] = 1'b0;
      tick();
      if (g == 0) bus_a.req_i[0] = 1'b1;
    end
    repeat (2) tick();

    // 4: dead generator times out on instance b, next requester is served
    bus_b.baud_sel_i = {3'd0, 3'd2, 3'd1, 3'd0};
    bus_b.req_i = 4'b0110;
    cyc = 0; gseen = 0;
    while (!err_b && cyc < 300) begin
      tick(); cyc++;
      if (bus_b.grant_o != '0) gseen++;
    end
    check("t4_err_latency", 32'(cyc), 32'd105);
    check("t4_err_id", 32'(errid_b), 32'd1);
    check("t4_no_grant", 32'(gseen), 32'd0);
    dead_b = 1'b0;
    cyc = 0;
    while (bus_b.grant_o == '0 && cyc < 300) begin tick(); cyc++; end
    check("t4_next_grant", 32'(bus_b.grant_o), 32'b0100);
    check("t4_err_pulses", 32'(err_cnt_b), 32'd1);
    bus_b.req_i = '0;

    // 5: withdraw during reconfiguration, then retry same code
    bus_a.req_i = 4'b0010;
    repeat (2) tick();
    bus_a.req_i = 4'b0000;
    tick();
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_grant", 32'(bus_a.grant_o), 32'd0);
    check("t5_rstn", 32'(rstn_a), 32'd0);
    repeat (3) tick();
    check("t5_no_err", 32'(err_cnt_a), 32'd0);
    bus_a.req_i = 4'b0010;
    wait_grant_a("t5", 2000, cyc, lowc);
    check("t5_latency", 32'(cyc), 32'd223);
    check("t5_rstn_low", 32'(lowc), 32'd4);
    check("t5_sel", 32'(sel_a), 32'd6);

    // 6: reset while requester 1 owns the generator
    bus_a.req_i = 4'b1010;
    repeat (2) tick();
    check("t6_pre_grant", 32'(bus_a.grant_o), 32'b0010);
    rst_a = 1'b1;
    tick();
    check("t6_grant", 32'(bus_a.grant_o), 32'd0);
    check("t6_rstn", 32'(rstn_a), 32'd0);
    check("t6_sel", 32'(sel_a), 32'd5);
    check("t6_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    wait_grant_a("t6", 2000, cyc, lowc);
    check("t6_first_grant", 32'(bus_a.grant_o), 32'b0010);
    bus_a.req_i = '0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
